data_path: RTL and testbench
============================

# data_path

Single-bus 32-bit processor datapath. It holds the general register file, special registers, the MDR input mux, the Y/Z ALU staging registers and the bus multiplexer. All transfers are driven by one-hot-style out/in strobes from the control unit. One cycle moves one bus value into any set of enabled registers.

## Interface
Parameters: none (data width fixed at 32, Z at 64).

Ports, in positional order:
- clock  in  1  system clock; all registers load on rising edge.
- clear  in  1  asynchronous, active-low reset; 0 forces every register to 0.
- Mdatain  in  32  memory read data, feeds MDR mux.
- RAout, R0out..R15out  in  1 each  drive RA / R0..R15 onto bus.
- RYout, RZHIout, RZLOout  in  1 each  drive Y / Z[63:32] / Z[31:0] onto bus.
- PCout, IRout, HIout, LOout, MDRout, PORTout  in  1 each  drive the named register onto bus.
- RAin, R0in..R15in  in  1 each  load bus into RA / R0..R15.
- RYin, RZin  in  1 each  load bus into Y; load ALU result into Z.
- PCin, IRin, HIin, LOin, MDRin, PORTin  in  1 each  load the named register (MDR from its mux).
- Read  in  1  MDR mux select: 1 = Mdatain, 0 = bus.

## Operation
- Registers: RA, R0–R15, Y, PC, IR, HI, LO, MDR, PORT are each 32 bits. Z is 64 bits.
- Register load: each register has an enable. On a rising edge with enable 1, it captures its source; otherwise it holds.
  - Source is the bus for all registers except MDR and Z.
  - MDR source: Read ? Mdatain : bus.
  - Z source: the ALU result.
- ALU: fixed adder. Result[63:0] = {32'b0, Y} + {32'b0, bus}. Bit 32 is the carry; Z[63:33] = 0.
- Bus is combinational. When several out strobes are high, the highest-priority source wins, in this order:
  - R0..R15, RA, HI, LO, RZHI, RZLO, PC, MDR, PORT, IR, RY (RY lowest).
  - No strobe high gives bus = 32'h0.
- A register may be both bus source and destination in one cycle; it captures the pre-edge value.
- R0 is an ordinary register: not hardwired to 0.

## Timing
- Reset: clear = 0 asynchronously zeroes all registers, including both halves of Z, regardless of clock. Strobes are ignored while clear = 0.
- Release: the first load is on the first rising edge with clear = 1.
- Transfer latency: a value on the bus or Mdatain appears in the destination register output one edge later. It is visible on the bus in the same cycle only via its out strobe.
- Y→Z add: Y is loaded on edge n, then RZin plus a bus source is applied in cycle n+1. Z is valid after edge n+1. ZLO → Rx lands after edge n+2.
- Simultaneous MDRout and RYout: MDR wins the bus. Y still feeds the ALU A-input directly.
- Overflow: 32'hFFFFFFFF + 1 gives ZLO = 0, ZHI = 1.

## Test plan
- Reset: load R1 = 9, drive clear = 0 mid-cycle → R1 and Z read 0 immediately, before any clock edge.
- MDR memory path: Read = 1, Mdatain = 7, MDRin pulse → MDRout shows 7 on bus. Then Read = 0 with R2out (R2 = 3), MDRin → MDR = 3.
- Add sequence:
  - MDR ← 7, then MDRout + RYin → Y = 7.
  - MDR ← 5, then RZin + MDRout + RYout → Z = 12.
  - RZLOout + R1in → R1 = 12.
- Carry: Y = 32'hFFFFFFFF, bus = 2, RZin → ZLO = 1, ZHI = 1.
- Register sweep: for each of RA, R0–R15, HI, LO, PC, IR, PORT: load a unique value via MDR, move it, read it back through its out strobe → exact match. Other registers are unchanged.
- Bus priority/idle: R3out and PCout together → R3 value on bus. No out strobe with R4in → R4 = 0.

Source files
------------

// File: rtl/data_path.sv
// Single-bus 32-bit datapath: register file, special registers, MDR input mux,
// Y/Z adder staging and a fixed-priority bus multiplexer driven by out/in strobes.
module data_path (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] Mdatain,
    input  logic        RAout,
    input  logic        R0out,
    input  logic        R1out,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        R8out,
    input  logic        R9out,
    input  logic        R10out,
    input  logic        R11out,
    input  logic        R12out,
    input  logic        R13out,
    input  logic        R14out,
    input  logic        R15out,
    input  logic        RYout,
    input  logic        RZHIout,
    input  logic        RZLOout,
    input  logic        PCout,
    input  logic        IRout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        MDRout,
    input  logic        PORTout,
    input  logic        RAin,
    input  logic        R0in,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        RYin,
    input  logic        RZin,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        MDRin,
    input  logic        PORTin,
    input  logic        Read,
    output logic [31:0] o_bus
);

    logic [31:0] r_gpr [16];
    logic [31:0] r_ra;
    logic [31:0] r_y;
    logic [63:0] r_z;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mdr;
    logic [31:0] r_port;

    logic [15:0] w_r_out;
    logic [15:0] w_r_in;
    logic [31:0] w_bus;
    logic [31:0] w_mdr_src;
    logic [63:0] w_alu;

    assign w_r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
    assign w_r_in  = {R15in,  R14in,  R13in,  R12in,  R11in,  R10in,  R9in,  R8in,
                      R7in,   R6in,   R5in,   R4in,   R3in,   R2in,   R1in,  R0in};

    // Sources are applied lowest priority first so later matches override; R0 ends up highest.
    always_comb begin
        w_bus = 32'h0;
        if (RYout)   w_bus = r_y;
        if (IRout)   w_bus = r_ir;
        if (PORTout) w_bus = r_port;
        if (MDRout)  w_bus = r_mdr;
        if (PCout)   w_bus = r_pc;
        if (RZLOout) w_bus = r_z[31:0];
        if (RZHIout) w_bus = r_z[63:32];
        if (LOout)   w_bus = r_lo;
        if (HIout)   w_bus = r_hi;
        if (RAout)   w_bus = r_ra;
        for (int i = 15; i >= 0; i--) begin
            if (w_r_out[i]) w_bus = r_gpr[i];
        end
    end

    assign w_mdr_src = Read ? Mdatain : w_bus;
    // Adder result is zero-extended; only bit 32 (carry) can be set in the upper half.
    assign w_alu     = {32'h0, r_y} + {32'h0, w_bus};
    assign o_bus     = w_bus;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) begin
                r_gpr[i] <= 32'h0;
            end
            r_ra   <= 32'h0;
            r_y    <= 32'h0;
            r_z    <= 64'h0;
            r_pc   <= 32'h0;
            r_ir   <= 32'h0;
            r_hi   <= 32'h0;
            r_lo   <= 32'h0;
            r_mdr  <= 32'h0;
            r_port <= 32'h0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (w_r_in[i]) r_gpr[i] <= w_bus;
            end
            if (RAin)   r_ra   <= w_bus;
            if (RYin)   r_y    <= w_bus;
            if (RZin)   r_z    <= w_alu;
            if (PCin)   r_pc   <= w_bus;
            if (IRin)   r_ir   <= w_bus;
            if (HIin)   r_hi   <= w_bus;
            if (LOin)   r_lo   <= w_bus;
            if (MDRin)  r_mdr  <= w_mdr_src;
            if (PORTin) r_port <= w_bus;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: each step drives strobes, clocks once and checks
// the bus against a hand-computed value with an immediate assertion.
module tb_data_path;

    logic        clock;
    logic        clear;
    logic [31:0] Mdatain;
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic        ra_out, ry_out, zhi_out, zlo_out, pc_out, ir_out, hi_out, lo_out, mdr_out, port_out;
    logic        ra_in, ry_in, z_in, pc_in, ir_in, hi_in, lo_in, mdr_in, port_in;
    logic        rd;
    logic [31:0] bus;

    int n_checks = 0;
    int n_err    = 0;

    data_path dut (
        .clock(clock), .clear(clear), .Mdatain(Mdatain),
        .RAout(ra_out),
        .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
        .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
        .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .RYout(ry_out), .RZHIout(zhi_out), .RZLOout(zlo_out),
        .PCout(pc_out), .IRout(ir_out), .HIout(hi_out), .LOout(lo_out),
        .MDRout(mdr_out), .PORTout(port_out),
        .RAin(ra_in),
        .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
        .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
        .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .RYin(ry_in), .RZin(z_in), .PCin(pc_in), .IRin(ir_in), .HIin(hi_in),
        .LOin(lo_in), .MDRin(mdr_in), .PORTin(port_in),
        .Read(rd),
        .o_bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        r_out = '0; r_in = '0;
        ra_out = 0; ry_out = 0; zhi_out = 0; zlo_out = 0; pc_out = 0; ir_out = 0;
        hi_out = 0; lo_out = 0; mdr_out = 0; port_out = 0;
        ra_in = 0; ry_in = 0; z_in = 0; pc_in = 0; ir_in = 0; hi_in = 0; lo_in = 0;
        mdr_in = 0; port_in = 0; rd = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    // id: 0..15 = R0..R15, 16 RA, 17 HI, 18 LO, 19 PC, 20 IR, 21 PORT
    task automatic set_out(input int id);
        if (id < 16) r_out[id] = 1'b1;
        else case (id)
            16: ra_out = 1'b1;
            17: hi_out = 1'b1;
            18: lo_out = 1'b1;
            19: pc_out = 1'b1;
            20: ir_out = 1'b1;
            default: port_out = 1'b1;
        endcase
    endtask

    task automatic set_in(input int id);
        if (id < 16) r_in[id] = 1'b1;
        else case (id)
            16: ra_in = 1'b1;
            17: hi_in = 1'b1;
            18: lo_in = 1'b1;
            19: pc_in = 1'b1;
            20: ir_in = 1'b1;
            default: port_in = 1'b1;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem_to_mdr(input logic [31:0] v);
        rd = 1'b1; Mdatain = v; mdr_in = 1'b1;
        step();
    endtask

    initial begin
        logic [31:0] val;
        idle();
        clear = 1'b0;
        Mdatain = 32'h0;
        #1;
        check("reset_bus_idle", bus, 32'h0);
        r_out[0] = 1'b1; #1;
        check("reset_r0", bus, 32'h0);
        idle(); zhi_out = 1'b1; #1;
        check("reset_zhi", bus, 32'h0);
        idle();
        #2 clear = 1'b1;

        // MDR memory path, then bus path
        mem_to_mdr(32'd7);
        mdr_out = 1'b1; #1;
        check("mdr_from_mem", bus, 32'd7);
        idle();
        mem_to_mdr(32'd3);
        mdr_out = 1'b1; r_in[2] = 1'b1;
        step();
        rd = 1'b0; Mdatain = 32'd99; r_out[2] = 1'b1; mdr_in = 1'b1;
        step();
        mdr_out = 1'b1; #1;
        check("mdr_from_bus", bus, 32'd3);
        idle();

        // Y <- 7, Z <- Y + MDR(5) with RYout also high, R1 <- ZLO
        mem_to_mdr(32'd7);
        mdr_out = 1'b1; ry_in = 1'b1;
        step();
        ry_out = 1'b1; #1;
        check("y_load", bus, 32'd7);
        idle();
        mem_to_mdr(32'd5);
        z_in = 1'b1; mdr_out = 1'b1; ry_out = 1'b1; #1;
        check("mdr_beats_ry", bus, 32'd5);
        step();
        zlo_out = 1'b1; r_in[1] = 1'b1;
        step();
        r_out[1] = 1'b1; #1;
        check("add_r1", bus, 32'd12);
        idle(); zhi_out = 1'b1; #1;
        check("add_zhi", bus, 32'd0);
        idle();

        // Carry out of the adder
        mem_to_mdr(32'hFFFF_FFFF);
        mdr_out = 1'b1; ry_in = 1'b1;
        step();
        mem_to_mdr(32'd2);
        mdr_out = 1'b1; z_in = 1'b1;
        step();
        zlo_out = 1'b1; #1;
        check("carry_zlo", bus, 32'd1);
        idle(); zhi_out = 1'b1; #1;
        check("carry_zhi", bus, 32'd1);
        idle();

        // Register sweep: load every register with a unique value, then read all back
        for (int id = 0; id < 22; id++) begin
            val = 32'hA500_0000 + 32'(id) * 32'h0001_0111;
            mem_to_mdr(val);
            mdr_out = 1'b1; set_in(id);
            step();
            set_out(id); #1;
            check($sformatf("sweep_load_%0d", id), bus, val);
            idle();
        end
        for (int id = 0; id < 22; id++) begin
            val = 32'hA500_0000 + 32'(id) * 32'h0001_0111;
            set_out(id); #1;
            check($sformatf("sweep_hold_%0d", id), bus, val);
            idle();
        end

        // Same-cycle source and destination: R5 <- R5 + nothing changes, R6 gets pre-edge R5
        r_out[5] = 1'b1; r_in[5] = 1'b1; r_in[6] = 1'b1;
        step();
        r_out[6] = 1'b1; #1;
        check("self_move", bus, 32'hA505_0555);
        idle();

        // Priority and idle bus
        r_out[3] = 1'b1; pc_out = 1'b1; #1;
        check("prio_r3_pc", bus, 32'hA503_0333);
        idle(); ra_out = 1'b1; hi_out = 1'b1; ir_out = 1'b1; #1;
        check("prio_ra_hi", bus, 32'hA510_1110);
        idle(); lo_out = 1'b1; zhi_out = 1'b1; #1;
        check("prio_lo_zhi", bus, 32'hA512_1332);
        idle(); r_out[15] = 1'b1; r_out[9] = 1'b1; #1;
        check("prio_r9_r15", bus, 32'hA509_0999);
        idle(); r_in[4] = 1'b1;
        step();
        r_out[4] = 1'b1; #1;
        check("idle_bus_r4", bus, 32'h0);
        idle();

        // Mid-cycle asynchronous reset
        mem_to_mdr(32'd9);
        mdr_out = 1'b1; r_in[1] = 1'b1;
        step();
        r_out[1] = 1'b1; #1;
        check("pre_reset_r1", bus, 32'd9);
        idle();
        #1 clear = 1'b0;
        #1 r_out[1] = 1'b1;
        #1 check("async_r1", bus, 32'h0);
        idle(); zlo_out = 1'b1; #1;
        check("async_zlo", bus, 32'h0);
        idle(); zhi_out = 1'b1; #1;
        check("async_zhi", bus, 32'h0);
        idle();
        rd = 1'b1; Mdatain = 32'h77; mdr_in = 1'b1; r_in[2] = 1'b1;
        step();
        clear = 1'b1;
        r_out[2] = 1'b1; #1;
        check("held_in_reset_r2", bus, 32'h0);
        idle(); mdr_out = 1'b1; #1;
        check("held_in_reset_mdr", bus, 32'h0);
        idle();
        mem_to_mdr(32'hAB);
        mdr_out = 1'b1; #1;
        check("first_load_after_release", bus, 32'hAB);
        idle();

        #10;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
